// File: rtl/pnr_trigger_core_if.sv
// Write port from the trigger core into the ADC FIFO that the PNR register file drains.
interface pnr_trigger_core_if #(
  parameter int ADC_W = 14
);
  logic                    fifo_wr_en_o;
  logic signed [ADC_W-1:0] fifo_din_o;
  logic                    fifo_full_i;

  // The core drives the write side; the FIFO owner reports fullness.
  modport master (output fifo_wr_en_o, output fifo_din_o, input fifo_full_i);
  modport slave  (input fifo_wr_en_o, input fifo_din_o, output fifo_full_i);
endinterface

// File: rtl/pnr_trigger_core.sv
// PNR trigger core: Schmitt-trigger edge detection on one ADC channel, delayed
// single-sample capture on the other, photon-number resolution against eight
// thresholds, and a FIFO push with saturating drop counting on overflow.
module pnr_trigger_core #(
  parameter int ADC_W = 14,
  parameter int NTHR  = 8,
  parameter int CNT_W = 32
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic signed [ADC_W-1:0] adc_a_i,
  input  logic signed [ADC_W-1:0] adc_b_i,
  input  logic                    trig_is_adc_a,
  input  logic signed [ADC_W-1:0] trig_threshold,
  input  logic [ADC_W-1:0]        trig_hysteresis,
  input  logic [CNT_W-1:0]        trig_clearance,
  input  logic                    trig_is_posedge,
  input  logic [CNT_W-1:0]        pnr_delay,
  input  logic [NTHR*ADC_W-1:0]   thr_i,
  pnr_trigger_core_if.master      fifo,
  output logic                    trig_o,
  output logic                    pnr_valid_o,
  output logic [3:0]              pnr_count_o,
  output logic                    busy_o,
  output logic [CNT_W-1:0]        drop_cnt_o
);

  // Two extra bits keep threshold +/- the full unsigned hysteresis range exact.
  localparam int SW = ADC_W + 2;
  // Cycle counter and clearance span need one bit more than the delay so that
  // pnr_delay + 1 never wraps.
  localparam int EW = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, DELAY, HOLD} state_t;

  // Number of thresholds the sample reaches or exceeds (signed compare).
  function automatic logic [3:0] photon_count(input logic signed [ADC_W-1:0] smp,
                                              input logic [NTHR*ADC_W-1:0]    thr);
    logic [3:0] n;
    n = '0;
    for (int k = 0; k < NTHR; k++) begin
      if (smp >= $signed(thr[k*ADC_W +: ADC_W])) n = n + 4'd1;
    end
    return n;
  endfunction

  // Increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Hold-off span: never shorter than the capture point plus one cycle.
  function automatic logic [EW-1:0] clear_span(input logic [CNT_W-1:0] clr,
                                               input logic [CNT_W-1:0] dly);
    logic [EW-1:0] min_span;
    min_span = {1'b0, dly} + EW'(1);
    return ({1'b0, clr} > min_span) ? {1'b0, clr} : min_span;
  endfunction

  logic signed [ADC_W-1:0] adc_a_p0, adc_b_p0;
  logic signed [ADC_W-1:0] x_p0, s_p0;
  logic signed [SW-1:0]    x_w, thr_w, hyst_w, lo_w, hi_w;
  logic                    arm_cond, fire_cond, fire, accept, capture;
  logic                    armed_q;
  state_t                  state_q, state_d;
  logic [EW-1:0]           cnt_q, span_q, span_new;
  logic [CNT_W-1:0]        dly_q;
  logic                    vld_p1, vld_p2;
  logic signed [ADC_W-1:0] smp_p1, din_p2;
  logic [3:0]              cnt_p2;
  logic [CNT_W-1:0]        drop_cnt_q;

  // ---- stage p0: registered ADC inputs ----
  // Register both raw ADC streams; everything downstream sees only these.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      adc_a_p0 <= '0;
      adc_b_p0 <= '0;
    end else begin
      adc_a_p0 <= adc_a_i;
      adc_b_p0 <= adc_b_i;
    end
  end

  assign x_p0 = trig_is_adc_a ? adc_a_p0 : adc_b_p0;
  assign s_p0 = trig_is_adc_a ? adc_b_p0 : adc_a_p0;

  assign x_w    = SW'(x_p0);
  assign thr_w  = SW'(trig_threshold);
  assign hyst_w = $signed({2'b00, trig_hysteresis});
  assign lo_w   = thr_w - hyst_w;
  assign hi_w   = thr_w + hyst_w;

  assign arm_cond  = trig_is_posedge ? (x_w < lo_w)   : (x_w > hi_w);
  assign fire_cond = trig_is_posedge ? (x_w >= thr_w) : (x_w <= thr_w);
  assign fire      = armed_q && fire_cond;
  assign accept    = fire && (state_q == IDLE);
  assign span_new  = clear_span(trig_clearance, pnr_delay);

  // Schmitt arming: a fire always disarms, so edges inside the hold-off are lost.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)       armed_q <= 1'b0;
    else if (fire)     armed_q <= 1'b0;
    else if (arm_cond) armed_q <= 1'b1;
  end

  // Next-state and capture decode; cnt_q holds cycles elapsed since acceptance.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (pnr_delay != '0) begin
            state_d = DELAY;
          end else begin
            capture = 1'b1;
            state_d = (span_new > EW'(1)) ? HOLD : IDLE;
          end
        end
      end
      DELAY: begin
        if (cnt_q == {1'b0, dly_q}) begin
          capture = 1'b1;
          state_d = (span_q == cnt_q + EW'(1)) ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (cnt_q + EW'(1) == span_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus configuration latched at acceptance.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      span_q  <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dly_q  <= pnr_delay;
        span_q <= span_new;
        cnt_q  <= EW'(1);
      end else if (state_q != IDLE) begin
        cnt_q <= cnt_q + EW'(1);
      end
    end
  end

  // ---- stage p1: captured detector sample ----
  // Hold the sample-channel value taken at the end of cycle T + d.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_p1 <= 1'b0;
      smp_p1 <= '0;
    end else begin
      vld_p1 <= capture;
      if (capture) smp_p1 <= s_p0;
    end
  end

  // ---- stage p2: photon number and FIFO data ----
  // Resolve the photon number and stage the FIFO word one cycle after capture.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_p2 <= 1'b0;
      cnt_p2 <= '0;
      din_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        cnt_p2 <= photon_count(smp_p1, thr_i);
        din_p2 <= smp_p1;
      end
    end
  end

  // Count results that could not be written because the FIFO was full.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                          drop_cnt_q <= '0;
    else if (vld_p2 && fifo.fifo_full_i) drop_cnt_q <= sat_inc(drop_cnt_q);
  end

  assign trig_o            = accept;
  assign busy_o            = (state_q != IDLE);
  assign pnr_valid_o       = vld_p2;
  assign pnr_count_o       = cnt_p2;
  assign fifo.fifo_wr_en_o = vld_p2 && !fifo.fifo_full_i;
  assign fifo.fifo_din_o   = din_p2;
  assign drop_cnt_o        = drop_cnt_q;

endmodule
